// File: rtl/horizontal_deskew.sv
// Re-aligns four staggered lanes (lane k arrives k*STEP late) into one group per out_valid.
// Latency 3*STEP+1 cycles (1 in bypass); no backpressure, downstream takes every out_valid.
module horizontal_deskew #(
  parameter int P_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] lane0_in,
  input  logic [P_WIDTH-1:0] lane1_in,
  input  logic [P_WIDTH-1:0] lane2_in,
  input  logic [P_WIDTH-1:0] lane3_in,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] lane0_out,
  output logic [P_WIDTH-1:0] lane1_out,
  output logic [P_WIDTH-1:0] lane2_out,
  output logic [P_WIDTH-1:0] lane3_out,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [1:0]         mode_q;
  logic [1:0]         mode_eff;
  logic [2:0]         step_q;
  logic [3:0]         drain_len;
  logic [3:0]         cnt;

  logic [P_WIDTH-1:0] dl0 [12];
  logic [P_WIDTH-1:0] dl1 [8];
  logic [P_WIDTH-1:0] dl2 [4];
  logic [11:0]        vpipe;

  logic [P_WIDTH-1:0] tap0, tap1, tap2;
  logic               tapv;

  function automatic logic [2:0] step_of(input logic [1:0] m);
    case (m)
      2'd0:    step_of = 3'd0;
      2'd1:    step_of = 3'd1;
      2'd2:    step_of = 3'd2;
      default: step_of = 3'd4;
    endcase
  endfunction

  // While a stream is in flight the latched mode governs the taps, so mode edits wait for IDLE.
  assign mode_eff  = (state == IDLE) ? mode : mode_q;
  assign step_q    = step_of(mode_q);
  assign drain_len = {1'b0, step_q} + {step_q, 1'b0};

  // Tap index for lane k is (3-k)*STEP; dlN[i] holds the sample from i+1 cycles ago.
  always_comb begin
    tap0 = lane0_in;
    tap1 = lane1_in;
    tap2 = lane2_in;
    tapv = in_valid;
    case (mode_eff)
      2'd1: begin
        tap0 = dl0[2];
        tap1 = dl1[1];
        tap2 = dl2[0];
        tapv = vpipe[2];
      end
      2'd2: begin
        tap0 = dl0[5];
        tap1 = dl1[3];
        tap2 = dl2[1];
        tapv = vpipe[5];
      end
      2'd3: begin
        tap0 = dl0[11];
        tap1 = dl1[7];
        tap2 = dl2[3];
        tapv = vpipe[11];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 12; i++) dl0[i] <= '0;
      for (int i = 0; i < 8; i++)  dl1[i] <= '0;
      for (int i = 0; i < 4; i++)  dl2[i] <= '0;
      vpipe <= '0;
    end else begin
      dl0[0] <= lane0_in;
      for (int i = 1; i < 12; i++) dl0[i] <= dl0[i-1];
      dl1[0] <= lane1_in;
      for (int i = 1; i < 8; i++)  dl1[i] <= dl1[i-1];
      dl2[0] <= lane2_in;
      for (int i = 1; i < 4; i++)  dl2[i] <= dl2[i-1];
      vpipe <= {vpipe[10:0], in_valid};
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_valid <= 1'b0;
      lane0_out <= '0;
      lane1_out <= '0;
      lane2_out <= '0;
      lane3_out <= '0;
    end else begin
      out_valid <= tapv;
      lane0_out <= tap0;
      lane1_out <= tap1;
      lane2_out <= tap2;
      lane3_out <= lane3_in;
    end
  end

  // DRAIN holds the latched mode until the last group's lane3 has reached the output register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= IDLE;
      mode_q <= 2'd0;
      cnt    <= 4'd0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q <= mode;
            state  <= RUN;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (!in_valid) begin
            if (step_q == 3'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt   <= drain_len;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          cnt <= cnt - 4'd1;
          if (in_valid) begin
            state <= RUN;
          end else if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_horizontal_deskew.sv
// Directed stimulus for horizontal_deskew with a cycle-history reference model and literal spot checks.
module tb_horizontal_deskew;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        in_valid = 1'b0;
  logic [63:0] lane_in [4];
  logic        out_valid;
  logic [63:0] lane0_out, lane1_out, lane2_out, lane3_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  horizontal_deskew #(.P_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .lane0_in(lane_in[0]), .lane1_in(lane_in[1]), .lane2_in(lane_in[2]), .lane3_in(lane_in[3]),
    .out_valid(out_valid),
    .lane0_out(lane0_out), .lane1_out(lane1_out), .lane2_out(lane2_out), .lane3_out(lane3_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int step_of(input logic [1:0] m);
    return (m == 2'd3) ? 4 : int'(m);
  endfunction

  // Reference model: every cycle's inputs are logged; an output is the logged input from
  // (3-k)*STEP+1 cycles earlier, STEP being the mode in force on the previous cycle.
  localparam int HN = 4096;
  logic        hv [HN];
  logic [63:0] hd [4][HN];
  int          effs [HN];
  int          cyc = 0;
  int          hbase = 0;
  int          last_v = -100000;
  int          lock_s = 0;

  function automatic logic getv(input int i);
    if (i < 0 || i < hbase) return 1'b0;
    return hv[i];
  endfunction

  function automatic logic [63:0] getd(input int k, input int i);
    if (i < 0 || i < hbase) return 64'd0;
    return hd[k][i];
  endfunction

  always @(negedge clk) begin
    logic [63:0] outs [4];
    logic busy_e, ov_e;
    int s, ms;
    outs[0] = lane0_out; outs[1] = lane1_out; outs[2] = lane2_out; outs[3] = lane3_out;
    if (cyc < HN) begin
      if (rst_n) begin
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        for (int k = 0; k < 4; k++) chk($sformatf("reset lane%0d", k), outs[k], 64'd0);
        hv[cyc] = 1'b0;
        for (int k = 0; k < 4; k++) hd[k][cyc] = 64'd0;
        effs[cyc] = 0;
        hbase = cyc + 1;
        last_v = -100000;
        lock_s = 0;
      end else begin
        busy_e = (cyc <= last_v + 1 + 3 * lock_s);
        if (cyc >= 1) begin
          s = effs[cyc-1];
          ov_e = getv(cyc - 1 - 3 * s);
          chk("model out_valid", {63'd0, out_valid}, {63'd0, ov_e});
          if (ov_e)
            for (int k = 0; k < 4; k++)
              chk($sformatf("model lane%0d", k), outs[k], getd(k, cyc - 1 - (3 - k) * s));
        end
        chk("model busy", {63'd0, busy}, {63'd0, busy_e});
        hv[cyc] = in_valid;
        for (int k = 0; k < 4; k++) hd[k][cyc] = lane_in[k];
        ms = step_of(mode);
        effs[cyc] = busy_e ? lock_s : ms;
        if (in_valid) begin
          if (!busy_e) lock_s = ms;
          last_v = cyc;
        end
      end
    end
    cyc++;
  end

  // Pattern runner: vpat marks the cycles (relative to start) where lane0 carries a group.
  bit          vpat [64];
  int          first_ov, n_ov;
  logic [63:0] first_l [4];
  logic [63:0] last_l [4];
  logic        bhist [128];

  task automatic set_v(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) vpat[i] = 1'b1;
  endtask

  task automatic clr_v();
    for (int i = 0; i < 64; i++) vpat[i] = 1'b0;
  endtask

  task automatic run_pat(input logic [1:0] m, input int len, input int sw_at, input logic [1:0] sw_mode,
                         input int sw_end, input int rst_at, input bit tag, input logic [63:0] base);
    int s, total, src;
    s = step_of(m);
    total = len + 3 * s + 16;
    first_ov = -1;
    n_ov = 0;
    for (int j = 0; j < total; j++) begin
      @(posedge clk);
      #1;
      rst_n = (rst_at >= 0 && j >= rst_at && j < rst_at + 2);
      mode = (j >= sw_at && j < sw_end) ? sw_mode : m;
      in_valid = (j < len) && vpat[j] && !(rst_at >= 0 && j >= rst_at);
      for (int k = 0; k < 4; k++) begin
        src = j - k * s;
        if (src >= 0 && src < len && vpat[src])
          lane_in[k] = tag ? (base + (64'(k) << 32) + 64'(src)) : 64'(src);
        else
          lane_in[k] = {$urandom, $urandom};
      end
      @(negedge clk);
      if (j < 128) bhist[j] = busy;
      if (out_valid) begin
        if (first_ov < 0) begin
          first_ov = j;
          first_l[0] = lane0_out; first_l[1] = lane1_out; first_l[2] = lane2_out; first_l[3] = lane3_out;
        end
        last_l[0] = lane0_out; last_l[1] = lane1_out; last_l[2] = lane2_out; last_l[3] = lane3_out;
        n_ov++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) lane_in[k] = 64'd0;
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;

    // Reset mid-stream: busy clears immediately, nothing emerges afterwards.
    clr_v(); set_v(0, 15);
    run_pat(2'd3, 16, 0, 2'd0, 0, 6, 1'b1, 64'h100);
    chk("t1 busy before reset", {63'd0, bhist[5]}, 64'd1);
    chk("t1 busy in reset", {63'd0, bhist[6]}, 64'd0);
    chk("t1 out_valid count", 64'(n_ov), 64'd0);

    // mode=3, 16 back-to-back groups, lane value = group index.
    clr_v(); set_v(0, 15);
    run_pat(2'd3, 16, 0, 2'd0, 0, -1, 1'b0, 64'h0);
    chk("t2 first out_valid", 64'(first_ov), 64'd13);
    chk("t2 out_valid count", 64'(n_ov), 64'd16);
    chk("t2 first lane3", first_l[3], 64'd0);
    chk("t2 last lane0", last_l[0], 64'd15);
    chk("t2 last lane3", last_l[3], 64'd15);
    chk("t2 busy end of drain", {63'd0, bhist[28]}, 64'd1);
    chk("t2 busy after drain", {63'd0, bhist[29]}, 64'd0);

    // Bypass: all lanes on one cycle, one cycle latency.
    clr_v(); set_v(0, 7);
    run_pat(2'd0, 8, 0, 2'd0, 0, -1, 1'b1, 64'h300);
    chk("t3 first out_valid", 64'(first_ov), 64'd1);
    chk("t3 out_valid count", 64'(n_ov), 64'd8);
    chk("t3 first lane2", first_l[2], 64'h0000_0002_0000_0300);
    chk("t3 last lane0", last_l[0], 64'h0000_0000_0000_0307);
    chk("t3 busy idle", {63'd0, bhist[9]}, 64'd0);

    // mode flips to 3 while busy at STEP=2: alignment holds at latency 7.
    clr_v(); set_v(0, 7);
    run_pat(2'd2, 8, 4, 2'd3, 8, -1, 1'b1, 64'h400);
    chk("t4 first out_valid", 64'(first_ov), 64'd7);
    chk("t4 out_valid count", 64'(n_ov), 64'd8);
    chk("t4 last lane1", last_l[1], 64'h0000_0001_0000_0407);
    clr_v(); set_v(0, 1);
    run_pat(2'd3, 2, 0, 2'd0, 0, -1, 1'b1, 64'h480);
    chk("t4b first out_valid", 64'(first_ov), 64'd13);

    // mode=3 with a 5-cycle gap landing in DRAIN, then 4 more groups.
    clr_v(); set_v(0, 3); set_v(9, 12);
    run_pat(2'd3, 13, 0, 2'd0, 0, -1, 1'b1, 64'h500);
    chk("t5 first out_valid", 64'(first_ov), 64'd13);
    chk("t5 out_valid count", 64'(n_ov), 64'd8);
    chk("t5 last lane3", last_l[3], 64'h0000_0003_0000_050C);
    chk("t5 busy through gap", {63'd0, bhist[7]}, 64'd1);

    // mode=1 single group A,B,C,D.
    clr_v(); set_v(0, 0);
    run_pat(2'd1, 1, 0, 2'd0, 0, -1, 1'b1, 64'hA0);
    chk("t6 first out_valid", 64'(first_ov), 64'd4);
    chk("t6 out_valid count", 64'(n_ov), 64'd1);
    chk("t6 lane0 A", first_l[0], 64'h0000_0000_0000_00A0);
    chk("t6 lane1 B", first_l[1], 64'h0000_0001_0000_00A0);
    chk("t6 lane2 C", first_l[2], 64'h0000_0002_0000_00A0);
    chk("t6 lane3 D", first_l[3], 64'h0000_0003_0000_00A0);
    chk("t6 busy in drain", {63'd0, bhist[4]}, 64'd1);
    chk("t6 busy cleared", {63'd0, bhist[5]}, 64'd0);

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
